// File: rtl/pm_loader_pkg.sv
// Shared types and constants for the program-memory loader.
package pm_loader_pkg;

  localparam logic [7:0] SyncByteDefault = 8'hA5;
  // One extra bit so a length byte of 0 can represent 256.
  localparam int unsigned LenWidth = 9;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StLen,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/pm_loader_csum.sv
// Running XOR over the data bytes of a load frame.
module pm_loader_csum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] csum
);

  logic [7:0] acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (enable) begin
      acc_q <= acc_q ^ data;
    end
  end

  assign csum = acc_q;

endmodule

// File: rtl/pm_loader.sv
// Streams a SYNC/length/data[/checksum] frame into program memory while holding the core in reset.
// Define PM_LOADER_CSUM_EN to require and verify a trailing XOR checksum byte.
module pm_loader
  import pm_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SyncByteDefault
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] pm_address,
  output logic [7:0] pm_data,
  output logic       pm_wren,
  output logic       micro_reset,
  output logic       busy,
  output logic       done,
  output logic       error
);

  state_e              state_q, state_d;
  logic [LenWidth-1:0] cnt_q, cnt_d;
  logic [LenWidth-1:0] len_q, len_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                wren_d;
  logic                mr_q, mr_d;
  logic                done_q, done_d;
  logic                xfer;

`ifdef PM_LOADER_CSUM_EN
  logic       err_q, err_d;
  logic       csum_clear, csum_en;
  logic [7:0] csum;

  pm_loader_csum u_csum (
    .clk    (clk),
    .reset  (reset),
    .clear  (csum_clear),
    .enable (csum_en),
    .data   (rx_data),
    .csum   (csum)
  );
`endif

  assign xfer = rx_valid && rx_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wren_d   = 1'b0;
    mr_d     = mr_q;
    done_d   = done_q;
    rx_ready = 1'b0;
    busy     = 1'b0;
`ifdef PM_LOADER_CSUM_EN
    err_d      = err_q;
    csum_clear = 1'b0;
    csum_en    = 1'b0;
`endif
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StSync;
          cnt_d   = '0;
          mr_d    = 1'b1;
          done_d  = 1'b0;
`ifdef PM_LOADER_CSUM_EN
          err_d      = 1'b0;
          csum_clear = 1'b1;
`endif
        end
      end
      StSync: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && (rx_data == SYNC_BYTE)) state_d = StLen;
      end
      StLen: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          len_d   = {(rx_data == 8'h00), rx_data};
          state_d = StData;
        end
      end
      StData: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          wren_d = 1'b1;
          data_d = rx_data;
          addr_d = cnt_q[7:0];
          cnt_d  = cnt_q + 1'b1;
`ifdef PM_LOADER_CSUM_EN
          csum_en = 1'b1;
          if (cnt_d == len_q) state_d = StCsum;
`else
          if (cnt_d == len_q) begin
            state_d = StDone;
            mr_d    = 1'b0;
            done_d  = 1'b1;
          end
`endif
        end
      end
`ifdef PM_LOADER_CSUM_EN
      StCsum: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          if (rx_data == csum) begin
            state_d = StDone;
            mr_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      pm_wren <= 1'b0;
      mr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pm_wren <= wren_d;
      mr_q    <= mr_d;
      done_q  <= done_d;
    end
  end

`ifdef PM_LOADER_CSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  assign pm_address  = addr_q;
  assign pm_data     = data_q;
  assign micro_reset = mr_q;
  assign done        = done_q;

endmodule

// File: tb/tb_pm_loader.sv
// Directed vector bench for pm_loader; expectations adapt to PM_LOADER_CSUM_EN.
module tb_pm_loader;

`ifdef PM_LOADER_CSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready, pm_wren, micro_reset, busy, done, error;
  logic [7:0] pm_address, pm_data;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[$];

  pm_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .pm_address  (pm_address),
    .pm_data     (pm_data),
    .pm_wren     (pm_wren),
    .micro_reset (micro_reset),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  // {wren, addr, data, rx_ready, busy, micro_reset, done, error}
  function automatic logic [21:0] obs();
    return {pm_wren, pm_address, pm_data, rx_ready, busy, micro_reset, done, error};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic vl, input logic [7:0] d, input logic wr,
                     input logic [7:0] ad, input logic [7:0] dt, input logic rr,
                     input logic bz, input logic mr, input logic dn, input logic er);
    vec_t v;
    v.start = st;
    v.valid = vl;
    v.data  = d;
    v.exp   = {wr, ad, dt, rr, bz, mr, dn, er};
    vecs.push_back(v);
  endtask

  task automatic step(input logic st, input logic vl, input logic [7:0] d);
    @(negedge clk);
    start    = st;
    rx_valid = vl;
    rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  localparam bit C = CsumEn;

  initial begin
    // Good frame 11,22,33 (checksum 00 when enabled); extra byte in DONE must be refused.
    add(1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 1, 0, 0);
    add(0, 1, 8'hA5, 0, 8'h00, 8'h00, 1, 1, 1, 0, 0);
    add(0, 1, 8'h03, 0, 8'h00, 8'h00, 1, 1, 1, 0, 0);
    add(0, 1, 8'h11, 1, 8'h00, 8'h11, 1, 1, 1, 0, 0);
    add(0, 1, 8'h22, 1, 8'h01, 8'h22, 1, 1, 1, 0, 0);
    add(0, 1, 8'h33, 1, 8'h02, 8'h33, C, C, C, !C, 0);
    add(0, 1, 8'h00, 0, 8'h02, 8'h33, 0, 0, 0, 1, 0);
    // Bad checksum frame 01,02 / FF, then start with a simultaneous byte.
    add(1, 0, 8'h00, 0, 8'h02, 8'h33, 1, 1, 1, 0, 0);
    add(0, 1, 8'hA5, 0, 8'h02, 8'h33, 1, 1, 1, 0, 0);
    add(0, 1, 8'h02, 0, 8'h02, 8'h33, 1, 1, 1, 0, 0);
    add(0, 1, 8'h01, 1, 8'h00, 8'h01, 1, 1, 1, 0, 0);
    add(0, 1, 8'h02, 1, 8'h01, 8'h02, C, C, C, !C, 0);
    add(0, 1, 8'hFF, 0, 8'h01, 8'h02, 0, 0, C, !C, C);
    add(1, 1, 8'hFF, 0, 8'h01, 8'h02, 1, 1, 1, 0, 0);
    // Junk before sync is discarded.
    add(0, 1, 8'h00, 0, 8'h01, 8'h02, 1, 1, 1, 0, 0);
    add(0, 1, 8'h7E, 0, 8'h01, 8'h02, 1, 1, 1, 0, 0);
    add(0, 1, 8'hA5, 0, 8'h01, 8'h02, 1, 1, 1, 0, 0);
    add(0, 1, 8'h01, 0, 8'h01, 8'h02, 1, 1, 1, 0, 0);
    add(0, 1, 8'h5A, 1, 8'h00, 8'h5A, C, C, C, !C, 0);
    add(0, 1, 8'h5A, 0, 8'h00, 8'h5A, 0, 0, 0, 1, 0);
    // start pulsed during DATA is ignored.
    add(1, 0, 8'h00, 0, 8'h00, 8'h5A, 1, 1, 1, 0, 0);
    add(0, 1, 8'hA5, 0, 8'h00, 8'h5A, 1, 1, 1, 0, 0);
    add(0, 1, 8'h02, 0, 8'h00, 8'h5A, 1, 1, 1, 0, 0);
    add(1, 1, 8'h10, 1, 8'h00, 8'h10, 1, 1, 1, 0, 0);
    add(1, 1, 8'h20, 1, 8'h01, 8'h20, C, C, C, !C, 0);
    add(0, 1, 8'h30, 0, 8'h01, 8'h20, 0, 0, 0, 1, 0);

    #2 reset = 1'b0;
    #1 check("reset state", 32'(obs()), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].start, vecs[i].valid, vecs[i].data);
      check($sformatf("vec %0d", i), 32'(obs()), 32'(vecs[i].exp));
    end

    // 256-byte frame (length byte 00), byte i at address i; XOR of 0..255 is 00.
    step(1, 0, 8'h00);
    step(0, 1, 8'hA5);
    step(0, 1, 8'h00);
    for (int i = 0; i < 256; i++) begin
      step(0, 1, i[7:0]);
      check($sformatf("len256 write %0d", i), 32'({pm_wren, pm_address, pm_data}),
            32'({1'b1, i[7:0], i[7:0]}));
    end
`ifdef PM_LOADER_CSUM_EN
    step(0, 1, 8'h00);
`endif
    step(0, 0, 8'h00);
    check("len256 end", 32'({pm_wren, pm_address, done, busy, micro_reset}),
          32'({1'b0, 8'hFF, 1'b1, 1'b0, 1'b0}));

    // Reset mid-frame after the second data byte of a 4-byte frame.
    step(1, 0, 8'h00);
    step(0, 1, 8'hA5);
    step(0, 1, 8'h04);
    step(0, 1, 8'h01);
    step(0, 1, 8'h02);
    check("pre-reset write", 32'({pm_wren, pm_address, pm_data}), 32'({1'b1, 8'h01, 8'h02}));
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b1;
    reset    = 1'b0;
    #1 check("async reset", 32'(obs()), 32'h0);
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    step(1, 0, 8'h00);
    step(0, 1, 8'hA5);
    step(0, 1, 8'h02);
    step(0, 1, 8'hAA);
    check("reload write 0", 32'({pm_wren, pm_address, pm_data}), 32'({1'b1, 8'h00, 8'hAA}));
    step(0, 1, 8'hBB);
    check("reload write 1", 32'({pm_wren, pm_address, pm_data}), 32'({1'b1, 8'h01, 8'hBB}));
`ifdef PM_LOADER_CSUM_EN
    step(0, 1, 8'h11);
`endif
    step(0, 0, 8'h00);
    check("reload done", 32'({pm_wren, done, error, micro_reset, busy}), 32'(5'b01000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
